// File: rtl/sub54_serial_pkg.sv
// Shared constants and state encoding for the bit-serial 5-bit minus 4-bit subtractor.
package sub54_serial_pkg;

  localparam int SUM_W = 5;
  localparam int A_W   = 4;
  localparam int NBITS = 5;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_e;

endpackage

// File: rtl/sub54_serial_full_sub1.sv
// 1-bit full subtractor: d = s - a - bin, with borrow out.
module full_sub1 (
  input  logic s_i,
  input  logic a_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = s_i ^ a_i ^ bin_i;
  assign bout_o = (~s_i & a_i) | (~(s_i ^ a_i) & bin_i);

endmodule

// File: rtl/sub54_serial.sv
// Bit-serial SUM - A: loads operands, resolves one difference bit per clock LSB-first,
// then publishes B/NEG/OVF with a one-cycle DONE pulse.
module sub54_serial
  import sub54_serial_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [SUM_W-1:0] SUM,
  input  logic [A_W-1:0]   A,
  output logic [A_W-1:0]   B,
  output logic             NEG,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   a_q, a_d;
  logic [SUM_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic [A_W-1:0]     b_q, b_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;

  logic               bit_d, bit_bout;

  full_sub1 u_fs (
    .s_i    (sum_q[0]),
    .a_i    (a_q[0]),
    .bin_i  (borrow_q),
    .d_o    (bit_d),
    .bout_o (bit_bout)
  );

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    a_d      = a_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    b_d      = b_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          sum_d    = SUM;
          a_d      = {1'b0, A};
          res_d    = '0;
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // operands shift right so bit 0 always feeds the subtractor
        sum_d    = sum_q >> 1;
        a_d      = a_q >> 1;
        res_d    = {bit_d, res_q[SUM_W-1:1]};
        borrow_d = bit_bout;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'(NBITS - 1)) begin
          state_d = S_FIN;
          b_d     = res_d[A_W-1:0];
          neg_d   = bit_bout;
          ovf_d   = res_d[SUM_W-1] & ~bit_bout;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      a_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      a_q      <= a_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign B    = b_q;
  assign NEG  = neg_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q != S_IDLE);
  assign DONE = (state_q == S_FIN);

endmodule

// File: tb/tb_sub54_serial.sv
// Bench for sub54_serial: directed table, exhaustive and random operands against an
// arithmetic reference, plus hand sequences for START filtering and mid-operation reset.
module tb_sub54_serial;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [4:0] SUM = '0;
  logic [3:0] A = '0;
  logic [3:0] B;
  logic       NEG, OVF, BUSY, DONE;

  int nvec = 0;
  int nerr = 0;

  sub54_serial dut (
    .CLK(CLK), .RST(RST), .START(START), .SUM(SUM), .A(A),
    .B(B), .NEG(NEG), .OVF(OVF), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] sum;
    logic [3:0] a;
    logic       neg;
    logic       ovf;
    logic [3:0] b;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {NEG, OVF, B} from plain integer subtraction
  function automatic logic [5:0] ref_model(input logic [4:0] s, input logic [3:0] a);
    int diff;
    logic neg, ovf;
    logic [3:0] b;
    diff = int'(s) - int'(a);
    neg  = (diff < 0);
    ovf  = !neg && (diff > 15);
    b    = 4'((diff + 32) % 16);
    return {neg, ovf, b};
  endfunction

  // One full operation; optionally scrambles inputs and START while the block is busy.
  task automatic run_op(input logic [4:0] s, input logic [3:0] a, input logic [5:0] exp,
                        input logic scr);
    logic [5:0] prev;
    int lat;
    bit seen;
    prev  = {NEG, OVF, B};
    SUM   = s;
    A     = a;
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("busy_after_load", BUSY, 1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 12) begin
      if (DONE) seen = 1;
      else begin
        chk("hold_during_shift", {NEG, OVF, B}, prev);
        if (scr) begin
          SUM   = 5'($urandom_range(31));
          A     = 4'($urandom_range(15));
          START = 1'($urandom_range(1));
        end
        tick();
        lat++;
      end
    end
    START = 1'b0;
    chk("done_latency", lat, 5);
    chk("result", {NEG, OVF, B}, exp);
    tick();
    chk("done_one_cycle", DONE, 0);
    chk("idle_after_fin", BUSY, 0);
  endtask

  initial begin
    int dones;
    tbl[0] = '{5'd2,  4'd1,  1'b0, 1'b0, 4'd1};
    tbl[1] = '{5'd22, 4'd7,  1'b0, 1'b0, 4'd15};
    tbl[2] = '{5'd30, 4'd15, 1'b0, 1'b0, 4'd15};
    tbl[3] = '{5'd3,  4'd4,  1'b1, 1'b0, 4'd15};
    tbl[4] = '{5'd20, 4'd2,  1'b0, 1'b1, 4'd2};
    tbl[5] = '{5'd0,  4'd0,  1'b0, 1'b0, 4'd0};
    tbl[6] = '{5'd31, 4'd0,  1'b0, 1'b1, 4'd15};
    tbl[7] = '{5'd0,  4'd15, 1'b1, 1'b0, 4'd1};
    tbl[8] = '{5'd16, 4'd0,  1'b0, 1'b1, 4'd0};
    tbl[9] = '{5'd15, 4'd15, 1'b0, 1'b0, 4'd0};

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("reset_outputs", {NEG, OVF, B}, 6'd0);
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].sum, tbl[i].a, {tbl[i].neg, tbl[i].ovf, tbl[i].b}, 1'b0);

    // START held through SHIFT and FIN: one DONE, first operands, re-accept after IDLE
    SUM = 5'd22; A = 4'd7; START = 1'b1;
    tick();
    SUM = 5'd3; A = 4'd4;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (DONE) dones++;
    end
    chk("fin_reached", DONE, 1);
    chk("first_operands", {NEG, OVF, B}, {1'b0, 1'b0, 4'd15});
    tick();
    chk("start_in_fin_ignored", BUSY, 0);
    chk("single_done", dones + int'(DONE), 1);
    tick();
    chk("reaccept_after_idle", BUSY, 1);
    START = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("second_done", DONE, 1);
    chk("second_result", {NEG, OVF, B}, {1'b1, 1'b0, 4'd15});
    tick();

    // reset on the 3rd SHIFT edge aborts with no DONE
    run_op(5'd20, 4'd2, ref_model(5'd20, 4'd2), 1'b0);
    SUM = 5'd30; A = 4'd1; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_busy", BUSY, 0);
    chk("abort_outputs", {NEG, OVF, B}, 6'd0);
    dones = int'(DONE);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (DONE) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_op(5'd2, 4'd1, 6'b00_0001, 1'b0);

    // reset wins over START in the same cycle
    RST = 1'b1; START = 1'b1; SUM = 5'd9; A = 4'd3;
    tick();
    RST = 1'b0; START = 1'b0;
    chk("rst_over_start", BUSY, 0);
    tick();
    chk("rst_over_start_idle", BUSY, 0);

    for (int s = 0; s < 32; s++)
      for (int a = 0; a < 16; a++)
        run_op(5'(s), 4'(a), ref_model(5'(s), 4'(a)), 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [4:0] rs;
      logic [3:0] ra;
      rs = 5'($urandom_range(31));
      ra = 4'($urandom_range(15));
      run_op(rs, ra, ref_model(rs, ra), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sub54_serial.md
SUB54_SERIAL -- requirements
Module: sub54_serial

Interface
REQ-001 The block SHALL use one clock and synchronous, active-high reset; ports listed below.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request; sampled only while idle.
REQ-005 SUM  input  5  minuend (adder-result width), unsigned.
REQ-006 A  input  4  subtrahend (known adder operand), unsigned.
REQ-007 B  output  4  recovered operand, low 4 bits of SUM - A.
REQ-008 NEG  output  1  final borrow; 1 iff SUM < A.
REQ-009 OVF  output  1  1 iff result > 15 (does not fit B) and NEG = 0.
REQ-010 BUSY  output  1  high while a subtraction is in progress.
REQ-011 DONE  output  1  one-cycle pulse; B/NEG/OVF valid.
REQ-012 Parameter: none; widths fixed at 5/4.

Function
REQ-013 States SHALL be IDLE, SHIFT, FIN; encoding from shared package.
REQ-014 IDLE: START=1 at edge k latches SUM and {1'b0,A}, clears borrow flop and 3-bit bit counter, enters SHIFT.
REQ-015 SHIFT: each edge computes one difference bit LSB-first, d = s ^ a ^ borrow, borrow' = (~s & a) | (~(s ^ a) & borrow), shifts d into 5-bit result register, increments counter.
REQ-016 After the 5th SHIFT edge (counter = 4) the state SHALL go to FIN; no further bits processed.
REQ-017 FIN: DONE=1 for exactly one cycle, then IDLE on next edge.
REQ-018 Latency: START sampled at edge k -> DONE high in cycle following edge k+5 (6 edges total including load).
REQ-019 BUSY SHALL be 1 in SHIFT and FIN, 0 in IDLE.
REQ-020 B = result[3:0]; NEG = final borrow; OVF = result[4] & ~NEG; all three registered, updated on FIN entry, held through IDLE until the next FIN.
REQ-021 B/NEG/OVF SHALL not change during SHIFT (internal result register separate from output registers).
REQ-022 START while BUSY SHALL be ignored, no queueing; SUM/A changes after load edge SHALL not affect the result.
REQ-023 START in the DONE cycle SHALL be ignored; earliest re-accept is the following IDLE cycle.
REQ-024 NEG=1 case: B SHALL equal (SUM - A) mod 16.

Reset
REQ-025 RST=1 at an edge SHALL force IDLE, B=0, NEG=0, OVF=0, BUSY=0, DONE=0, counter=0, borrow=0, regardless of state (incl. mid-SHIFT; aborted operation produces no DONE).
REQ-026 RST SHALL take priority over START in the same cycle.

Structure
REQ-027 Shared package SHALL hold the state enum, width constants (SUM_W=5, A_W=4) and bit-count constant (5).
REQ-028 One sub-module, full_sub1 (1-bit full subtractor: s, a, bin -> d, bout), SHALL be instantiated once in the datapath.

Verification
REQ-029 SUM=00010, A=0001, START -> after 6 edges DONE pulse, B=0001, NEG=0, OVF=0.
REQ-030 SUM=10110 (22), A=0111 -> B=1111, NEG=0, OVF=0; SUM=11110, A=1111 -> B=1111.
REQ-031 SUM=00011, A=0100 -> NEG=1, B=1111, OVF=0; SUM=10100, A=0010 -> OVF=1, B=0010.
REQ-032 START pulsed again during SHIFT and in DONE cycle -> ignored; exactly one DONE, result of first operands.
REQ-033 RST asserted at 3rd SHIFT edge -> next cycle BUSY=0, all outputs 0, no DONE; fresh START then completes normally.
REQ-034 Exhaustive loop over all SUM in 0..31, A in 0..15 -> {NEG,OVF,B} matches SUM - A reference model.
